mips_multicycle_ctrl: RTL and testbench
=======================================

// Module: mips_multicycle_ctrl
// PURPOSE
//  Multicycle MIPS control FSM: sequences one shared ALU/memory datapath over 3-5 cycles per instruction.
//  Supports RTYPE, LW, SW, BEQ, ADDI, J, LB (op codes as in the single-cycle decoder).
//  Adds memory wait states (mem_ready), a memory-timeout watchdog and a halt state for illegal ops.
// PARAMETERS
//  MAX_WAIT  15  max consecutive mem_ready=0 cycles tolerated in a memory state before halting (1..255)
// PORTS
//  clk          in   1  clock, all state updates on rising edge
//  reset        in   1  synchronous, active-low (reset==0 at posedge -> reset)
//  op           in   6  opcode from instruction register (IR)
//  zero         in   1  ALU zero flag
//  mem_ready    in   1  memory access completes this cycle
//  pcen         out  1  PC load enable = pcwrite | (branch & zero)
//  iord         out  1  0: mem addr = PC, 1: mem addr = ALUOut
//  irwrite      out  1  load IR
//  memwrite     out  1  memory write strobe
//  membyteread  out  1  byte load (LB) select for memory data path
//  regwrite     out  1  register file write
//  regdst       out  1  0: rt, 1: rd
//  memtoreg     out  1  0: ALUOut, 1: Data reg
//  alusrca      out  1  0: PC, 1: A
//  alusrcb      out  2  00: B, 01: 4, 10: SignImm, 11: SignImm<<2
//  pcsrc        out  2  00: ALUResult, 01: ALUOut, 10: jump target
//  aluop        out  2  00 add, 01 sub, 10 funct-decoded
//  halted       out  1  FSM in HALT
//  illegal_op   out  1  sticky: HALT entered by unknown opcode
//  mem_timeout  out  1  sticky: HALT entered by watchdog
// BEHAVIOUR
//  States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP, HALT.
//  Reset: state=FETCH, wait counter=0, illegal_op=mem_timeout=0. Outputs Moore (plus pcen/irwrite gating); every
//   control output not listed for a state is 0 (pcsrc/alusrcb/aluop = 00).
//  FETCH:   iord=0 alusrca=0 alusrcb=01 aluop=00 pcsrc=00; irwrite=pcwrite=mem_ready. Stay until mem_ready -> DECODE.
//  DECODE:  alusrca=0 alusrcb=11 aluop=00. Next by op: LW/SW/LB->MEMADR, RTYPE->EXECUTE, BEQ->BRANCH,
//           ADDI->ADDIEX, J->JUMP, other->HALT and set illegal_op.
//  MEMADR:  alusrca=1 alusrcb=10 aluop=00. LW/LB->MEMRD, SW->MEMWR.
//  MEMRD:   iord=1, membyteread=(op==LB). Stay until mem_ready -> MEMWB.
//  MEMWB:   regdst=0 memtoreg=1 regwrite=1 membyteread=(op==LB) -> FETCH.
//  MEMWR:   iord=1 memwrite=1 (held every cycle until mem_ready) -> FETCH.
//  EXECUTE: alusrca=1 alusrcb=00 aluop=10 -> ALUWB.  ALUWB: regdst=1 memtoreg=0 regwrite=1 -> FETCH.
//  BRANCH:  alusrca=1 alusrcb=00 aluop=01 pcsrc=01 branch=1 (pcen=zero) -> FETCH.
//  ADDIEX:  alusrca=1 alusrcb=10 aluop=00 -> ADDIWB.  ADDIWB: regdst=0 memtoreg=0 regwrite=1 -> FETCH.
//  JUMP:    pcsrc=10 pcwrite=1 (pcen=1) -> FETCH.
//  HALT:    all controls 0, halted=1; exits only by reset.
//  Latency: RTYPE/ADDI/LW-not-waiting 4/4/5, SW 4, BEQ/J 3 cycles incl. FETCH; +1 per wait cycle.
//  Watchdog: 8-bit counter, cleared on entry to FETCH/MEMRD/MEMWR and whenever mem_ready=1; increments each
//   cycle in those states with mem_ready=0. When counter==MAX_WAIT and mem_ready=0 -> HALT, set mem_timeout
//   (i.e. MAX_WAIT wait cycles allowed, the (MAX_WAIT+1)th stall halts). mem_ready=1 on that same cycle wins.
//  op is sampled combinationally; IR stability guaranteed since irwrite only pulses at end of FETCH.
//  Reset asserted mid-instruction: next state FETCH, no write strobes asserted in the reset cycle's successor
//   beyond FETCH defaults; sticky flags cleared.
// TESTING
//  reset=0 two cycles, release -> halted=0, FETCH outputs, irwrite=0 while mem_ready=0, counter idle.
//  LW (op=100011), mem_ready=1 always -> 5 cycles, regwrite=1 memtoreg=1 only in cycle 5, back to FETCH.
//  LB with mem_ready low 3 cycles in MEMRD -> MEMRD held 4 cycles, membyteread=1 in MEMRD and MEMWB.
//  BEQ zero=1 -> pcen=1 pcsrc=01 in cycle 3; zero=0 -> pcen=0; J -> pcen=1 pcsrc=10; SW memwrite held until ready.
//  op=111111 -> HALT after DECODE, illegal_op=1, stays until reset; reset clears flag and restarts FETCH.
//  mem_ready=0 for 16 cycles in FETCH (MAX_WAIT=15) -> HALT with mem_timeout=1; ready on 16th stall -> no halt.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM with memory wait states, a stall watchdog and
// a halt state for unknown opcodes.
//
// state   | meaning
// FETCH   | read instruction at PC, PC+4 written when memory ready
// DECODE  | read registers, precompute branch target
// MEMADR  | compute load/store address
// MEMRD   | read data memory (waits on mem_ready)
// MEMWB   | write loaded data to rt
// MEMWR   | write data memory (waits on mem_ready)
// EXECUTE | R-type ALU operation
// ALUWB   | write ALU result to rd
// BRANCH  | compare, take branch if zero
// ADDIEX  | add immediate
// ADDIWB  | write ALU result to rt
// JUMP    | load jump target into PC
// HALT    | stopped; leaves only on reset
module mips_multicycle_ctrl #(
   parameter int unsigned MAX_WAIT = 15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pcen,
   output logic       iord,
   output logic       irwrite,
   output logic       memwrite,
   output logic       membyteread,
   output logic       regwrite,
   output logic       regdst,
   output logic       memtoreg,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsrc,
   output logic [1:0] aluop,
   output logic       halted,
   output logic       illegal_op,
   output logic       mem_timeout
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_LB    = 6'b100000;

   localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXECUTE,
      S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP, S_HALT
   } state_t;

   state_t     state, state_nx;
   logic [7:0] wait_cnt, wait_cnt_nx;
   logic       pcwrite, branch;
   logic       wait_state, stall, timeout_hit, illegal_set;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= S_FETCH;
         wait_cnt    <= 8'd0;
         illegal_op  <= 1'b0;
         mem_timeout <= 1'b0;
      end else begin
         state       <= state_nx;
         wait_cnt    <= wait_cnt_nx;
         illegal_op  <= illegal_op | illegal_set;
         mem_timeout <= mem_timeout | timeout_hit;
      end
   end

   always_comb begin
      state_nx    = state;
      pcwrite     = 1'b0;
      branch      = 1'b0;
      iord        = 1'b0;
      irwrite     = 1'b0;
      memwrite    = 1'b0;
      membyteread = 1'b0;
      regwrite    = 1'b0;
      regdst      = 1'b0;
      memtoreg    = 1'b0;
      alusrca     = 1'b0;
      alusrcb     = 2'b00;
      pcsrc       = 2'b00;
      aluop       = 2'b00;
      halted      = 1'b0;
      illegal_set = 1'b0;

      // Counter is zero outside the wait states, so every entry starts clean.
      wait_state  = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
      stall       = wait_state && !mem_ready;
      timeout_hit = stall && (wait_cnt == WAIT_LIMIT);
      wait_cnt_nx = (stall && !timeout_hit) ? wait_cnt + 8'd1 : 8'd0;

      case (state)
         S_FETCH: begin
            alusrcb = 2'b01;
            irwrite = mem_ready;
            pcwrite = mem_ready;
            if (mem_ready) state_nx = S_DECODE;
         end
         S_DECODE: begin
            alusrcb = 2'b11;
            case (op)
               OP_LW, OP_SW, OP_LB: state_nx = S_MEMADR;
               OP_RTYPE:            state_nx = S_EXECUTE;
               OP_BEQ:              state_nx = S_BRANCH;
               OP_ADDI:             state_nx = S_ADDIEX;
               OP_J:                state_nx = S_JUMP;
               default: begin
                  state_nx    = S_HALT;
                  illegal_set = 1'b1;
               end
            endcase
         end
         S_MEMADR: begin
            alusrca  = 1'b1;
            alusrcb  = 2'b10;
            state_nx = (op == OP_SW) ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            iord        = 1'b1;
            membyteread = (op == OP_LB);
            if (mem_ready) state_nx = S_MEMWB;
         end
         S_MEMWB: begin
            memtoreg    = 1'b1;
            regwrite    = 1'b1;
            membyteread = (op == OP_LB);
            state_nx    = S_FETCH;
         end
         S_MEMWR: begin
            iord     = 1'b1;
            memwrite = 1'b1;
            if (mem_ready) state_nx = S_FETCH;
         end
         S_EXECUTE: begin
            alusrca  = 1'b1;
            aluop    = 2'b10;
            state_nx = S_ALUWB;
         end
         S_ALUWB: begin
            regdst   = 1'b1;
            regwrite = 1'b1;
            state_nx = S_FETCH;
         end
         S_BRANCH: begin
            alusrca  = 1'b1;
            aluop    = 2'b01;
            pcsrc    = 2'b01;
            branch   = 1'b1;
            state_nx = S_FETCH;
         end
         S_ADDIEX: begin
            alusrca  = 1'b1;
            alusrcb  = 2'b10;
            state_nx = S_ADDIWB;
         end
         S_ADDIWB: begin
            regwrite = 1'b1;
            state_nx = S_FETCH;
         end
         S_JUMP: begin
            pcsrc    = 2'b10;
            pcwrite  = 1'b1;
            state_nx = S_FETCH;
         end
         S_HALT: begin
            halted = 1'b1;
         end
         default: state_nx = S_HALT;
      endcase

      if (timeout_hit) state_nx = S_HALT;
   end

   assign pcen = pcwrite | (branch & zero);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: vector table, hand-written corner sequences
// and a randomized run against a per-instruction phase-list model.
module tb_mips_multicycle_ctrl;

   localparam int MAX_WAIT = 15;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_LB    = 6'b100000;
   localparam logic [5:0] OP_BAD   = 6'b111111;

   typedef enum int {
      P_FETCH, P_DECODE, P_MEMADR, P_MEMRD, P_MEMWB, P_MEMWR, P_EXEC,
      P_ALUWB, P_BRANCH, P_ADDIEX, P_ADDIWB, P_JUMP, P_HALT
   } phase_t;

   typedef struct {
      logic [5:0]  op;
      logic        mr;
      logic        z;
      logic [17:0] exp;
      string       nm;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset, zero, mem_ready;
   logic [5:0] op;
   logic       pcen, iord, irwrite, memwrite, membyteread, regwrite, regdst, memtoreg, alusrca;
   logic [1:0] alusrcb, pcsrc, aluop;
   logic       halted, illegal_op, mem_timeout;
   logic [17:0] dut_w;

   int compared = 0;
   int mismatched = 0;

   vec_t   tbl[$];
   phase_t q[$];
   logic [5:0] legal_ops [7];

   always #5 clk = ~clk;

   mips_multicycle_ctrl #(.MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
      .pcen(pcen), .iord(iord), .irwrite(irwrite), .memwrite(memwrite),
      .membyteread(membyteread), .regwrite(regwrite), .regdst(regdst),
      .memtoreg(memtoreg), .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
      .aluop(aluop), .halted(halted), .illegal_op(illegal_op), .mem_timeout(mem_timeout)
   );

   assign dut_w = {pcen, iord, irwrite, memwrite, membyteread, regwrite, regdst, memtoreg,
                   alusrca, alusrcb, pcsrc, aluop, halted, illegal_op, mem_timeout};

   // Expected control word for a phase, straight from the per-state output list.
   function automatic logic [17:0] ctl(phase_t p, logic [5:0] o, logic mr, logic z,
                                       logic ill, logic tmo);
      logic e_pcen = 0, e_iord = 0, e_irw = 0, e_mw = 0, e_mbr = 0, e_rw = 0;
      logic e_rd = 0, e_m2r = 0, e_asa = 0, e_hlt = 0;
      logic [1:0] e_asb = 0, e_psrc = 0, e_aop = 0;
      case (p)
         P_FETCH:  begin e_asb = 2'b01; e_irw = mr; e_pcen = mr; end
         P_DECODE: e_asb = 2'b11;
         P_MEMADR: begin e_asa = 1; e_asb = 2'b10; end
         P_MEMRD:  begin e_iord = 1; e_mbr = (o == OP_LB); end
         P_MEMWB:  begin e_rw = 1; e_m2r = 1; e_mbr = (o == OP_LB); end
         P_MEMWR:  begin e_iord = 1; e_mw = 1; end
         P_EXEC:   begin e_asa = 1; e_aop = 2'b10; end
         P_ALUWB:  begin e_rd = 1; e_rw = 1; end
         P_BRANCH: begin e_asa = 1; e_aop = 2'b01; e_psrc = 2'b01; e_pcen = z; end
         P_ADDIEX: begin e_asa = 1; e_asb = 2'b10; end
         P_ADDIWB: e_rw = 1;
         P_JUMP:   begin e_psrc = 2'b10; e_pcen = 1; end
         P_HALT:   e_hlt = 1;
         default:  e_hlt = 0;
      endcase
      return {e_pcen, e_iord, e_irw, e_mw, e_mbr, e_rw, e_rd, e_m2r, e_asa,
              e_asb, e_psrc, e_aop, e_hlt, ill, tmo};
   endfunction

   task automatic check(input string nm, input logic [17:0] exp);
      @(negedge clk);
      compared++;
      if (dut_w !== exp) begin
         mismatched++;
         $display("FAIL %s: got %b expected %b", nm, dut_w, exp);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic apply(input string nm, input logic [5:0] o, input logic mr, input logic z,
                        input logic rst, input phase_t ph, input logic ill, input logic tmo);
      op = o; mem_ready = mr; zero = z; reset = rst;
      check(nm, ctl(ph, o, mr, z, ill, tmo));
      reset = 1'b1;
   endtask

   task automatic do_reset();
      reset = 1'b0; mem_ready = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
   endtask

   function automatic void add(logic [5:0] o, logic mr, logic z, phase_t ph, string nm);
      vec_t v;
      v.op = o; v.mr = mr; v.z = z; v.nm = nm;
      v.exp = ctl(ph, o, mr, z, 1'b0, 1'b0);
      tbl.push_back(v);
   endfunction

   function automatic void push_instr(logic [5:0] o);
      q.push_back(P_DECODE);
      case (o)
         OP_RTYPE:     begin q.push_back(P_EXEC); q.push_back(P_ALUWB); end
         OP_LW, OP_LB: begin q.push_back(P_MEMADR); q.push_back(P_MEMRD); q.push_back(P_MEMWB); end
         OP_SW:        begin q.push_back(P_MEMADR); q.push_back(P_MEMWR); end
         OP_BEQ:       q.push_back(P_BRANCH);
         OP_ADDI:      begin q.push_back(P_ADDIEX); q.push_back(P_ADDIWB); end
         OP_J:         q.push_back(P_JUMP);
         default:      q.push_back(P_HALT);
      endcase
   endfunction

   initial begin
      logic [5:0] cur_op;
      logic ill, tmo;
      int stalls, hcnt;
      phase_t ph;

      legal_ops = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, OP_LB};
      reset = 1'b0; op = OP_RTYPE; zero = 1'b0; mem_ready = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b1;

      // Sequential vector table starting right after reset.
      add(OP_LW, 0, 0, P_FETCH, "reset_fetch_idle");
      add(OP_LW, 1, 0, P_FETCH, "lw_fetch");
      add(OP_LW, 1, 0, P_DECODE, "lw_decode");
      add(OP_LW, 1, 0, P_MEMADR, "lw_memadr");
      add(OP_LW, 1, 0, P_MEMRD, "lw_memrd");
      add(OP_LW, 1, 0, P_MEMWB, "lw_memwb");
      add(OP_LB, 1, 0, P_FETCH, "lb_fetch");
      add(OP_LB, 0, 0, P_DECODE, "lb_decode");
      add(OP_LB, 0, 0, P_MEMADR, "lb_memadr");
      add(OP_LB, 0, 0, P_MEMRD, "lb_memrd_w1");
      add(OP_LB, 0, 0, P_MEMRD, "lb_memrd_w2");
      add(OP_LB, 0, 0, P_MEMRD, "lb_memrd_w3");
      add(OP_LB, 1, 0, P_MEMRD, "lb_memrd_rdy");
      add(OP_LB, 0, 0, P_MEMWB, "lb_memwb");
      add(OP_BEQ, 1, 1, P_FETCH, "beq1_fetch");
      add(OP_BEQ, 0, 1, P_DECODE, "beq1_decode");
      add(OP_BEQ, 0, 1, P_BRANCH, "beq_taken");
      add(OP_BEQ, 1, 0, P_FETCH, "beq0_fetch");
      add(OP_BEQ, 0, 0, P_DECODE, "beq0_decode");
      add(OP_BEQ, 0, 0, P_BRANCH, "beq_not_taken");
      add(OP_J, 1, 0, P_FETCH, "j_fetch");
      add(OP_J, 0, 0, P_DECODE, "j_decode");
      add(OP_J, 0, 0, P_JUMP, "j_jump");
      add(OP_SW, 1, 0, P_FETCH, "sw_fetch");
      add(OP_SW, 0, 0, P_DECODE, "sw_decode");
      add(OP_SW, 0, 0, P_MEMADR, "sw_memadr");
      add(OP_SW, 0, 0, P_MEMWR, "sw_memwr_w1");
      add(OP_SW, 0, 0, P_MEMWR, "sw_memwr_w2");
      add(OP_SW, 1, 0, P_MEMWR, "sw_memwr_rdy");
      add(OP_RTYPE, 1, 0, P_FETCH, "r_fetch");
      add(OP_RTYPE, 0, 0, P_DECODE, "r_decode");
      add(OP_RTYPE, 0, 0, P_EXEC, "r_exec");
      add(OP_RTYPE, 0, 0, P_ALUWB, "r_aluwb");
      add(OP_ADDI, 0, 0, P_FETCH, "addi_fetch_wait");
      add(OP_ADDI, 1, 0, P_FETCH, "addi_fetch");
      add(OP_ADDI, 1, 0, P_DECODE, "addi_decode");
      add(OP_ADDI, 1, 0, P_ADDIEX, "addi_ex");
      add(OP_ADDI, 1, 0, P_ADDIWB, "addi_wb");
      add(OP_ADDI, 0, 0, P_FETCH, "back_to_fetch");
      for (int i = 0; i < tbl.size(); i++) begin
         op = tbl[i].op; mem_ready = tbl[i].mr; zero = tbl[i].z;
         check(tbl[i].nm, tbl[i].exp);
      end

      // Illegal opcode halts, sticks, and is cleared by reset.
      do_reset();
      apply("ill_fetch", OP_BAD, 1, 0, 1, P_FETCH, 0, 0);
      apply("ill_decode", OP_BAD, 0, 0, 1, P_DECODE, 0, 0);
      for (int i = 0; i < 3; i++) apply("ill_halt", OP_RTYPE, i[0], 0, 1, P_HALT, 1, 0);
      apply("ill_halt_reset", OP_RTYPE, 1, 0, 0, P_HALT, 1, 0);
      apply("ill_after_reset", OP_RTYPE, 0, 0, 1, P_FETCH, 0, 0);

      // Sixteen stalls in FETCH trip the watchdog.
      do_reset();
      for (int i = 0; i < MAX_WAIT + 1; i++) apply("wd_fetch_stall", OP_RTYPE, 0, 0, 1, P_FETCH, 0, 0);
      apply("wd_fetch_halt", OP_RTYPE, 0, 0, 1, P_HALT, 0, 1);
      apply("wd_fetch_halt_stays", OP_RTYPE, 1, 0, 1, P_HALT, 0, 1);

      // Ready on the sixteenth stall cycle wins over the watchdog.
      do_reset();
      for (int i = 0; i < MAX_WAIT; i++) apply("wd_edge_stall", OP_RTYPE, 0, 0, 1, P_FETCH, 0, 0);
      apply("wd_edge_ready", OP_RTYPE, 1, 0, 1, P_FETCH, 0, 0);
      apply("wd_edge_decode", OP_RTYPE, 0, 0, 1, P_DECODE, 0, 0);
      apply("wd_edge_exec", OP_RTYPE, 0, 0, 1, P_EXEC, 0, 0);

      // Watchdog in MEMRD.
      do_reset();
      apply("wd_rd_fetch", OP_LW, 1, 0, 1, P_FETCH, 0, 0);
      apply("wd_rd_decode", OP_LW, 0, 0, 1, P_DECODE, 0, 0);
      apply("wd_rd_memadr", OP_LW, 0, 0, 1, P_MEMADR, 0, 0);
      for (int i = 0; i < MAX_WAIT + 1; i++) apply("wd_rd_stall", OP_LW, 0, 0, 1, P_MEMRD, 0, 0);
      apply("wd_rd_halt", OP_LW, 0, 0, 1, P_HALT, 0, 1);

      // Reset asserted mid-instruction restarts at FETCH.
      do_reset();
      apply("mid_fetch", OP_RTYPE, 1, 0, 1, P_FETCH, 0, 0);
      apply("mid_decode", OP_RTYPE, 0, 0, 1, P_DECODE, 0, 0);
      apply("mid_exec_reset", OP_RTYPE, 0, 0, 0, P_EXEC, 0, 0);
      apply("mid_after_reset", OP_RTYPE, 0, 0, 1, P_FETCH, 0, 0);

      // Randomized run against the phase-list model.
      do_reset();
      q.delete(); q.push_back(P_FETCH);
      cur_op = op; ill = 0; tmo = 0; stalls = 0; hcnt = 0;
      for (int c = 0; c < 3000; c++) begin
         mem_ready = ($urandom_range(0, 9) < 6);
         zero = 1'($urandom_range(0, 1));
         reset = (q[0] == P_HALT && hcnt == 3) ? 1'b0 : 1'b1;
         check("rand", ctl(q[0], cur_op, mem_ready, zero, ill, tmo));
         if (!reset) begin
            reset = 1'b1;
            q.delete(); q.push_back(P_FETCH);
            ill = 0; tmo = 0; stalls = 0; hcnt = 0;
            continue;
         end
         ph = q[0];
         if (ph == P_HALT) begin
            hcnt++;
         end else if ((ph == P_FETCH || ph == P_MEMRD || ph == P_MEMWR) && !mem_ready) begin
            stalls++;
            if (stalls == MAX_WAIT + 1) begin
               q.delete(); q.push_back(P_HALT); tmo = 1; stalls = 0;
            end
         end else begin
            stalls = 0;
            void'(q.pop_front());
            if (ph == P_DECODE && q.size() > 0 && q[0] == P_HALT) ill = 1;
            if (ph == P_FETCH) begin
               if ($urandom_range(0, 19) == 0) cur_op = OP_BAD;
               else cur_op = legal_ops[$urandom_range(0, 6)];
               op = cur_op;
               push_instr(cur_op);
            end
            if (q.size() == 0) q.push_back(P_FETCH);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
